eth_tx_framer: RTL and testbench
================================

# eth_tx_framer

Turns a raw payload byte stream into a complete Ethernet II frame for the RMII transmit path. It adds the 7-byte preamble and SFD, zero-pads short payloads to the minimum length, appends the IEEE 802.3 CRC-32 FCS, and then holds off for the inter-frame gap. It sits between the payload source (ROM/RAM read driver, fetched by index) and `bytes_to_dibits`, emitting one byte every `BYTE_PERIOD` cycles so the dibit serializer runs at the RMII line rate.

## Interface
- `BYTE_PERIOD`, 4: clk cycles per output byte (4 dibits at 50 MHz).
- `PREAMBLE_LEN`, 7: count of 0x55 bytes before the SFD.
- `MIN_PAYLOAD`, 60: payload bytes after padding, excluding FCS. 0 disables padding.
- `IFG_BYTES`, 12: inter-frame gap, in byte times.
- `clk  in  1`: system clock, 50 MHz.
- `reset  in  1`: synchronous, active-high.
- `start  in  1`: one-cycle pulse. Accepted only in IDLE.
- `len  in  11`: payload byte count, 0..1514. Sampled on an accepted `start`.
- `in_req  out  1`: one-cycle pulse requesting payload byte `in_index`.
- `in_index  out  11`: payload byte index. Valid while `in_req` is high.
- `in_ready  in  1`: one-cycle pulse; `in_data` is valid.
- `in_data  in  8`: payload byte.
- `out  out  8`: frame byte. Valid on `outclk`.
- `outclk  out  1`: one-cycle strobe per frame byte; connects to `bytes_to_dibits.inclk`.
- `done  out  1`: one-cycle pulse coincident with the last FCS `outclk`.
- `busy  out  1`: high from the cycle after an accepted `start` through the end of IFG.
- `underrun  out  1`: sticky error flag; cleared on an accepted `start` or on `reset`.

## Operation
- States: IDLE → PREAMBLE → SFD → PAYLOAD → PAD → FCS → IFG → IDLE.
  - PAYLOAD is skipped if `len` = 0.
  - PAD is skipped if `len` ≥ `MIN_PAYLOAD`.
- Byte values per state:
  - PREAMBLE emits 0x55 `PREAMBLE_LEN` times.
  - SFD emits 0xD5 once.
  - PAYLOAD emits `len` bytes from the source.
  - PAD emits 0x00 (`MIN_PAYLOAD` − `len`) times.
  - FCS emits 4 bytes.
- Fetch: `in_req` for payload byte k is issued together with the `outclk` of the byte preceding it. For k=0 that byte is the SFD. `in_index` = k.
  - The source must return `in_ready` within `BYTE_PERIOD`−1 cycles.
  - The captured byte is held in a 1-byte buffer.
  - If no `in_ready` arrives before the slot's `outclk`, emit 0x00, set `underrun`, and continue the frame.
  - An `in_ready` with no request outstanding is ignored.
- CRC:
  - Reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF.
  - Updated once per emitted PAYLOAD and PAD byte, LSB first.
  - FCS = ~crc, sent as crc[7:0] first, then [15:8], [23:16], [31:24].
  - Preamble and SFD are excluded from the CRC.
- Byte counter: 11 bits. Period counter: clog2(`BYTE_PERIOD`) bits, wrapping at `BYTE_PERIOD`−1.
- `start` while `busy` is ignored, including during IFG, and `len` is not resampled.
- Reset at any time: next cycle is IDLE, and `out`=0, `outclk`=0, `done`=0, `busy`=0, `in_req`=0, `in_index`=0, `underrun`=0. No `done` is generated for an aborted frame.

## Timing
- Reset values of all outputs: 0.
- An accepted `start` in cycle T gives:
  - `busy`=1 from T+1;
  - first `outclk` (0x55) at T+1;
  - subsequent `outclk` every `BYTE_PERIOD` cycles.
- Total `outclk` count per frame: `PREAMBLE_LEN` + 1 + max(`len`, `MIN_PAYLOAD`) + 4.
- Nth `outclk` (N from 0) is at T+1+N·`BYTE_PERIOD`.
- `done` coincides with the last `outclk`.
- IFG lasts `IFG_BYTES`·`BYTE_PERIOD` cycles after the last `outclk`'s slot ends. `busy` falls in the cycle after IFG ends, and `start` is accepted again from that cycle.
- `out` holds its value between strobes. `outclk` is never high on two consecutive cycles.
- Default frame with `len`=60: 72 bytes, last `outclk` at T+1+71·4 = T+285, `busy` low at T+1+72·4+48 = T+337.

## Test plan
- `MIN_PAYLOAD`=0, `len`=9, payload "123456789" (0x31..0x39), source latency 1 cycle:
  - bytes are 55×7, D5, 31..39, then FCS 26 39 F4 CB;
  - 21 `outclk`s; `done` on the 21st; `underrun`=0.
- Defaults, `len`=4, payload DE AD BE EF:
  - 8-byte header, 4 payload bytes, 56 bytes of 0x00, then 4 FCS bytes equal to the reference-model CRC;
  - 72 strobes, spaced exactly 4 cycles apart.
- Defaults, `len`=0: 8-byte header, 60 bytes of 0x00, FCS; no `in_req` is ever asserted.
- Source never responds on index 2 (`len`=10):
  - slot for index 2 emits 0x00 and `underrun`=1;
  - remaining bytes continue; frame length is unchanged;
  - next accepted `start` clears `underrun`.
- `start` pulses at T+3 and during IFG are ignored. `start` in the first cycle with `busy`=0 begins a new frame on the next cycle.
- Assert `reset` mid-PAYLOAD:
  - all outputs are 0 the next cycle, with no `done`;
  - a fresh `start` produces a correct complete frame.

Source files
------------

// File: rtl/eth_tx_framer_if.sv
// Framer control, payload-fetch and frame-byte signals bundled into one port.
// Latency: none; wires only.
// Backpressure: none; fetch uses req/ready pulses and the output side is a fixed-rate strobe.
interface eth_tx_framer_if;
    logic        start;
    logic [10:0] len;
    logic        in_req;
    logic [10:0] in_index;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [7:0]  out;
    logic        outclk;
    logic        done;
    logic        busy;
    logic        underrun;

    // Framer side: masters the fetch request and the outgoing byte strobe.
    modport master (
        input  start, len, in_ready, in_data,
        output in_req, in_index, out, outclk, done, busy, underrun
    );

    // Environment side: issues start, answers fetches, consumes frame bytes.
    modport slave (
        output start, len, in_ready, in_data,
        input  in_req, in_index, out, outclk, done, busy, underrun
    );
endinterface

// File: rtl/eth_tx_framer.sv
// Builds an Ethernet II frame (preamble, SFD, payload, zero pad, FCS, IFG) from a fetched payload stream.
// Latency: first byte strobe one cycle after an accepted start, then one byte every BYTE_PERIOD cycles.
// Backpressure: none; a payload byte not returned in time goes out as 0x00 and sets the sticky underrun flag.
module eth_tx_framer #(
    parameter int BYTE_PERIOD  = 4,
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_PAYLOAD  = 60,
    parameter int IFG_BYTES    = 12
) (
    input  logic              clk,
    input  logic              reset,
    eth_tx_framer_if.master   bus
);
    localparam int PW = (BYTE_PERIOD > 1) ? $clog2(BYTE_PERIOD) : 1;
    localparam logic [PW-1:0] P_LAST    = PW'(BYTE_PERIOD - 1);
    localparam logic [10:0]   MIN_L     = 11'(MIN_PAYLOAD);
    localparam logic [10:0]   PRE_LAST  = 11'(PREAMBLE_LEN - 1);
    localparam logic [10:0]   IFG_LAST  = 11'(IFG_BYTES - 1);

    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, PAYLOAD, PAD, FCS, IFG} state_t;

    state_t      state_q, state_d;
    logic [10:0] bcnt_q, bcnt_d;     // byte index within the current state (data index across PAYLOAD/PAD)
    logic [PW-1:0] pcnt_q, pcnt_d;   // cycle position inside the current byte slot
    logic [10:0] len_q, len_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  buf_q, buf_d;       // one-byte holding buffer for the fetched payload byte
    logic        have_q, have_d;     // buffer holds the byte for the next payload slot
    logic        wait_q, wait_d;     // a fetch is outstanding
    logic [7:0]  out_q, out_d;
    logic        outclk_q, outclk_d;
    logic        done_q, done_d;
    logic        req_q, req_d;
    logic [10:0] idx_q, idx_d;
    logic        udr_q, udr_d;

    logic        tick;
    logic [10:0] data_len;
    logic        fetch_ok;
    logic [7:0]  fetch_byte;
    logic        emit_data;
    logic        emit_fcs0;
    logic [10:0] d_idx;
    logic [7:0]  data_byte;
    logic [31:0] fcs_w;
    logic [1:0]  fidx;

    // Reflected CRC-32 update over one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    assign tick       = (pcnt_q == P_LAST);
    assign data_len   = (len_q > MIN_L) ? len_q : MIN_L;
    // A response landing in the emit cycle itself is forwarded straight to the output.
    assign fetch_ok   = have_q | (wait_q & bus.in_ready);
    assign fetch_byte = have_q ? buf_q : ((wait_q & bus.in_ready) ? bus.in_data : 8'h00);
    assign fcs_w      = ~crc_q;
    assign fidx       = bcnt_q[1:0] + 2'd1;

    // Next-state, datapath and output decode; every slot boundary is a tick of the period counter.
    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        pcnt_d    = pcnt_q;
        len_d     = len_q;
        crc_d     = crc_q;
        buf_d     = buf_q;
        have_d    = have_q;
        wait_d    = wait_q;
        out_d     = out_q;
        idx_d     = idx_q;
        udr_d     = udr_q;
        outclk_d  = 1'b0;
        done_d    = 1'b0;
        req_d     = 1'b0;
        emit_data = 1'b0;
        emit_fcs0 = 1'b0;
        d_idx     = '0;
        data_byte = 8'h00;

        if (wait_q && bus.in_ready) begin
            buf_d  = bus.in_data;
            have_d = 1'b1;
            wait_d = 1'b0;
        end

        if (state_q != IDLE) pcnt_d = tick ? '0 : pcnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = PREAMBLE;
                    bcnt_d   = '0;
                    pcnt_d   = '0;
                    len_d    = bus.len;
                    crc_d    = 32'hFFFFFFFF;
                    udr_d    = 1'b0;
                    have_d   = 1'b0;
                    wait_d   = 1'b0;
                    out_d    = 8'h55;
                    outclk_d = 1'b1;
                end
            end
            PREAMBLE: begin
                if (tick) begin
                    outclk_d = 1'b1;
                    if (bcnt_q == PRE_LAST) begin
                        state_d = SFD;
                        bcnt_d  = '0;
                        out_d   = 8'hD5;
                        // Payload byte 0 is requested together with the SFD strobe.
                        if (len_q != 11'd0) begin
                            req_d  = 1'b1;
                            idx_d  = '0;
                            wait_d = 1'b1;
                            have_d = 1'b0;
                        end
                    end else begin
                        bcnt_d = bcnt_q + 11'd1;
                        out_d  = 8'h55;
                    end
                end
            end
            SFD: begin
                if (tick) begin
                    if (data_len == 11'd0) emit_fcs0 = 1'b1;
                    else                   emit_data = 1'b1;
                end
            end
            PAYLOAD, PAD: begin
                if (tick) begin
                    if (bcnt_q + 11'd1 == data_len) emit_fcs0 = 1'b1;
                    else begin
                        emit_data = 1'b1;
                        d_idx     = bcnt_q + 11'd1;
                    end
                end
            end
            FCS: begin
                if (tick) begin
                    if (bcnt_q == 11'd3) begin
                        state_d = (IFG_BYTES == 0) ? IDLE : IFG;
                        bcnt_d  = '0;
                        if (IFG_BYTES == 0) pcnt_d = '0;
                    end else begin
                        bcnt_d   = bcnt_q + 11'd1;
                        out_d    = fcs_w[{fidx, 3'b000} +: 8];
                        outclk_d = 1'b1;
                        done_d   = (bcnt_q == 11'd2);
                    end
                end
            end
            IFG: begin
                if (tick) begin
                    if (bcnt_q == IFG_LAST) begin
                        state_d = IDLE;
                        pcnt_d  = '0;
                    end else begin
                        bcnt_d = bcnt_q + 11'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (emit_data) begin
            bcnt_d   = d_idx;
            outclk_d = 1'b1;
            if (d_idx < len_q) begin
                state_d   = PAYLOAD;
                data_byte = fetch_byte;
                if (!fetch_ok) udr_d = 1'b1;
                have_d = 1'b0;
                wait_d = 1'b0;
                // Prefetch the following payload byte alongside this strobe.
                if (d_idx + 11'd1 < len_q) begin
                    req_d  = 1'b1;
                    idx_d  = d_idx + 11'd1;
                    wait_d = 1'b1;
                end
            end else begin
                state_d = PAD;
            end
            out_d = data_byte;
            crc_d = crc_byte(crc_q, data_byte);
        end

        if (emit_fcs0) begin
            state_d  = FCS;
            bcnt_d   = '0;
            out_d    = fcs_w[7:0];
            outclk_d = 1'b1;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            bcnt_q   <= '0;
            pcnt_q   <= '0;
            len_q    <= '0;
            crc_q    <= '0;
            buf_q    <= '0;
            have_q   <= 1'b0;
            wait_q   <= 1'b0;
            out_q    <= '0;
            outclk_q <= 1'b0;
            done_q   <= 1'b0;
            req_q    <= 1'b0;
            idx_q    <= '0;
            udr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            pcnt_q   <= pcnt_d;
            len_q    <= len_d;
            crc_q    <= crc_d;
            buf_q    <= buf_d;
            have_q   <= have_d;
            wait_q   <= wait_d;
            out_q    <= out_d;
            outclk_q <= outclk_d;
            done_q   <= done_d;
            req_q    <= req_d;
            idx_q    <= idx_d;
            udr_q    <= udr_d;
        end
    end

    assign bus.out      = out_q;
    assign bus.outclk   = outclk_q;
    assign bus.done     = done_q;
    assign bus.in_req   = req_q;
    assign bus.in_index = idx_q;
    assign bus.underrun = udr_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_eth_tx_framer.sv
// Bench for eth_tx_framer: randomized frames checked every cycle against a frame-level model.
// Latency: model expects strobe N at T+1+N*4 after a start accepted in cycle T.
// Backpressure: source answers fetches after 1..3 cycles, can drop one index, and injects stray ready pulses.
module tb_eth_tx_framer;
    localparam int P    = 4;
    localparam int PRE  = 7;
    localparam int MINP = 60;
    localparam int IFG  = 12;
    localparam int NONE = 4095;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] payload  [0:2047];
    logic [7:0] payload0 [0:15];
    int   drop_idx = NONE;

    eth_tx_framer_if bus();
    eth_tx_framer_if bus0();

    eth_tx_framer dut (.clk(clk), .reset(rst), .bus(bus));
    eth_tx_framer #(.MIN_PAYLOAD(0)) dut0 (.clk(clk), .reset(rst), .bus(bus0));

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // ---------------- frame-level reference model ----------------
    logic [7:0] m_bytes [$];
    int   m_have = 0, m_T = 0, m_n = 0, m_len = 0, m_drop = NONE;
    logic [7:0] m_last = 8'h00;
    bit   m_valid = 0;

    task automatic build_frame();
        int dl;
        logic [31:0] c;
        logic [7:0] b;
        m_bytes.delete();
        for (int i = 0; i < PRE; i++) m_bytes.push_back(8'h55);
        m_bytes.push_back(8'hD5);
        dl = (m_len > MINP) ? m_len : MINP;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < dl; i++) begin
            b = (i < m_len && i != m_drop) ? payload[i] : 8'h00;
            m_bytes.push_back(b);
            c = ref_crc(c, b);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) m_bytes.push_back(c[8*i +: 8]);
        m_n = m_bytes.size();
    endtask

    // Compare every DUT output against the model each cycle, then fold in start/reset.
    initial begin : compare
        int rel, n_idx;
        bit strobe, e_busy, e_udr, e_req;
        forever begin
            @(negedge clk);
            strobe = 0; n_idx = 0; e_busy = 0; e_udr = 0;
            if (m_valid) begin
                if (m_have != 0) begin
                    rel = cyc - m_T - 1;
                    if (rel >= 0 && rel % P == 0 && rel / P < m_n) begin
                        strobe = 1;
                        n_idx  = rel / P;
                    end
                    e_busy = (cyc > m_T) && (cyc <= m_T + m_n * P + IFG * P);
                    e_udr  = (m_drop < m_len) && (cyc >= m_T + 1 + (PRE + 1 + m_drop) * P);
                end
                if (strobe) m_last = m_bytes[n_idx];
                e_req = strobe && n_idx >= PRE && n_idx < PRE + m_len;
                check("outclk", bus.outclk, strobe);
                check("out", bus.out, m_last);
                check("done", bus.done, strobe && n_idx == m_n - 1);
                check("busy", bus.busy, e_busy);
                check("underrun", bus.underrun, e_udr);
                check("in_req", bus.in_req, e_req);
                if (e_req) check("in_index", bus.in_index, n_idx - PRE);
            end
            if (rst) begin
                m_valid = 1; m_have = 0; m_last = 8'h00;
            end else if (m_valid && bus.start && !e_busy) begin
                m_have = 1; m_T = cyc; m_len = int'(bus.len); m_drop = drop_idx;
                build_frame();
            end
        end
    end

    // Payload source for the main DUT: random 1..3 cycle latency, optional dropped index, stray pulses.
    initial begin : src
        int cnt, idx;
        cnt = 0; idx = 0;
        bus.in_ready = 1'b0; bus.in_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            bus.in_ready = 1'b0;
            bus.in_data  = 8'($urandom);
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.in_ready = 1'b1;
                    bus.in_data  = payload[idx];
                end
            end
            if (bus.in_req) begin
                if (int'(bus.in_index) != drop_idx) begin
                    cnt = $urandom_range(1, 3);
                    idx = int'(bus.in_index);
                end
            end else if (cnt == 0 && !bus.in_ready && drop_idx == NONE && $urandom_range(0, 7) == 0) begin
                bus.in_ready = 1'b1;
            end
        end
    end

    // Payload source for the unpadded DUT: fixed one-cycle latency.
    initial begin : src0
        bit pend;
        int idx;
        pend = 0; idx = 0;
        bus0.in_ready = 1'b0; bus0.in_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            bus0.in_ready = pend;
            bus0.in_data  = pend ? payload0[idx] : 8'hA5;
            pend = bus0.in_req;
            idx  = int'(bus0.in_index) & 15;
        end
    end

    logic [7:0] got0 [$];
    int done_cnt0 = 0, done_at0 = 0;

    // Collect the unpadded DUT's strobed bytes and where done lands.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (bus0.outclk) got0.push_back(bus0.out);
            if (bus0.done) begin
                done_cnt0++;
                done_at0 = got0.size();
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(input int l);
        bus.start = 1'b1;
        bus.len   = 11'(l);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (bus.busy && k < budget) begin
            tick();
            k++;
        end
        check("idle_timeout", bus.busy, 0);
    endtask

    task automatic fill_payload();
        for (int i = 0; i < 2048; i++) payload[i] = 8'($urandom);
    endtask

    initial begin : main
        logic [7:0] exp0 [21];
        logic [31:0] c;
        int t0, k, l, gap;

        bus.start = 1'b0; bus.len = '0;
        bus0.start = 1'b0; bus0.len = '0;
        fill_payload();
        for (int i = 0; i < 16; i++) payload0[i] = 8'h31 + 8'(i);

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_out", bus.out, 0);
        check("rst_outclk", bus.outclk, 0);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_in_req", bus.in_req, 0);
        check("rst_in_index", bus.in_index, 0);
        check("rst_underrun", bus.underrun, 0);

        // Model pin: CRC-32 of "123456789".
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 9; i++) c = ref_crc(c, payload0[i]);
        check("model_crc", ~c, 32'hCBF43926);

        // Unpadded frame of "123456789" against literal bytes.
        for (int i = 0; i < PRE; i++) exp0[i] = 8'h55;
        exp0[7] = 8'hD5;
        for (int i = 0; i < 9; i++) exp0[8 + i] = 8'h31 + 8'(i);
        exp0[17] = 8'h26; exp0[18] = 8'h39; exp0[19] = 8'hF4; exp0[20] = 8'hCB;
        got0.delete();
        bus0.start = 1'b1; bus0.len = 11'd9;
        tick();
        bus0.start = 1'b0;
        k = 0;
        while (bus0.busy && k < 400) begin tick(); k++; end
        check("f0_idle", bus0.busy, 0);
        check("f0_count", got0.size(), 21);
        for (int i = 0; i < 21 && i < got0.size(); i++) check("f0_byte", got0[i], exp0[i]);
        check("f0_done_cnt", done_cnt0, 1);
        check("f0_done_pos", done_at0, 21);
        check("f0_underrun", bus0.underrun, 0);

        // Padded short payload DE AD BE EF.
        payload[0] = 8'hDE; payload[1] = 8'hAD; payload[2] = 8'hBE; payload[3] = 8'hEF;
        pulse_start(4);
        wait_idle(1000);

        // len=60 timing, ignored starts at T+3 and in IFG, then restart in first idle cycle with len=0.
        fill_payload();
        pulse_start(60);
        t0 = cyc - 1;
        tick(); tick();
        pulse_start(5);
        k = 0;
        while (!bus.done && k < 400) begin tick(); k++; end
        check("done_time", cyc - t0, 285);
        repeat (10) tick();
        pulse_start(7);
        wait_idle(200);
        check("idle_time", cyc - t0, 337);
        pulse_start(0);
        wait_idle(1000);

        // Source never answers index 2; next accepted start clears underrun.
        fill_payload();
        drop_idx = 2;
        pulse_start(10);
        wait_idle(1000);
        check("underrun_sticky", bus.underrun, 1);
        drop_idx = NONE;
        pulse_start(3);
        check("underrun_clear", bus.underrun, 0);
        wait_idle(1000);

        // Reset in the middle of the payload, then a fresh frame.
        fill_payload();
        pulse_start(30);
        repeat (50) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out", bus.out, 0);
        check("abort_outclk", bus.outclk, 0);
        check("abort_done", bus.done, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_in_req", bus.in_req, 0);
        check("abort_in_index", bus.in_index, 0);
        check("abort_underrun", bus.underrun, 0);
        repeat (4) tick();
        pulse_start(20);
        wait_idle(1000);

        // Randomized frames including length boundaries.
        for (int f = 0; f < 14; f++) begin
            case (f)
                0: l = 1514;
                1: l = 59;
                2: l = 61;
                3: l = 1;
                default: l = $urandom_range(0, 120);
            endcase
            fill_payload();
            drop_idx = (l > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, l - 1) : NONE;
            pulse_start(l);
            wait_idle(8000);
            drop_idx = NONE;
            gap = $urandom_range(0, 6);
            repeat (gap) tick();
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
